// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: hazard-detection inputs from the ID/EX/MEM stages,
// data-bus handshake, and the stall/flush/freeze outputs back to the pipeline.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_rt_is_source;
    logic                  id_is_branch;
    logic                  branch_taken;
    logic                  jump;
    logic [REG_ADDR_W-1:0] ex_dst_reg;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] mem_dst_reg;
    logic                  mem_reg_write;
    logic                  mem_mem_read;
    logic                  d_req;
    logic                  wb_done_i;
    logic                  stat_clr_i;
    logic                  pc_write;
    logic                  if_id_write_en;
    logic                  hazard_detected_o;
    logic                  if_id_flush_o;
    logic                  pstop_o;
    logic                  mem_timeout_o;
    logic [CNT_W-1:0]      stall_count_o;

    // Pipeline side: supplies stage information, consumes the controls.
    modport master (
        output id_rs, id_rt, id_rt_is_source, id_is_branch, branch_taken, jump,
               ex_dst_reg, ex_reg_write, ex_mem_read,
               mem_dst_reg, mem_reg_write, mem_mem_read,
               d_req, wb_done_i, stat_clr_i,
        input  pc_write, if_id_write_en, hazard_detected_o, if_id_flush_o,
               pstop_o, mem_timeout_o, stall_count_o
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_rt_is_source, id_is_branch, branch_taken, jump,
               ex_dst_reg, ex_reg_write, ex_mem_read,
               mem_dst_reg, mem_reg_write, mem_mem_read,
               d_req, wb_done_i, stat_clr_i,
        output pc_write, if_id_write_en, hazard_detected_o, if_id_flush_o,
               pstop_o, mem_timeout_o, stall_count_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, control
// flush, bounded data-memory wait with sticky timeout, saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int BRANCH_IN_ID = 1,
    parameter int TIMEOUT      = 16,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    // TIMEOUT=0 still needs a 1-bit counter so the declarations stay legal.
    localparam int WCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic load_use, branch_hz, hazard;
    logic pstop, timeout_evt;
    logic pc_write, hazard_out, flush;

    // Register-match terms and raw hazard (before the freeze takes priority).
    always_comb begin
        ex_hit_rs  = bus.ex_reg_write && (bus.ex_dst_reg != '0)
                     && (bus.ex_dst_reg == bus.id_rs);
        ex_hit_rt  = bus.ex_reg_write && (bus.ex_dst_reg != '0)
                     && (bus.ex_dst_reg == bus.id_rt) && bus.id_rt_is_source;
        mem_hit_rs = bus.mem_reg_write && (bus.mem_dst_reg != '0)
                     && (bus.mem_dst_reg == bus.id_rs);
        mem_hit_rt = bus.mem_reg_write && (bus.mem_dst_reg != '0)
                     && (bus.mem_dst_reg == bus.id_rt) && bus.id_rt_is_source;
        load_use   = bus.ex_mem_read && (ex_hit_rs || ex_hit_rt);
        branch_hz  = 1'b0;
        if (BRANCH_IN_ID != 0) begin
            branch_hz = bus.id_is_branch
                        && ((ex_hit_rs || ex_hit_rt)
                            || (bus.mem_mem_read && (mem_hit_rs || mem_hit_rt)));
        end
        hazard = load_use || branch_hz;
    end

    // Memory-wait FSM next state; pstop is a Mealy output of the current state.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        pstop       = 1'b0;
        timeout_evt = 1'b0;
        unique case (state_q)
            IDLE: begin
                pstop = bus.d_req && !bus.wb_done_i;
                if (pstop) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = WCNT_ONE;
                end
            end
            MEM_WAIT: begin
                if (bus.wb_done_i) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else if ((TIMEOUT != 0) && (wcnt_q == WCNT_LIMIT)) begin
                    // Give up: the pipeline advances with undefined read data.
                    timeout_evt = 1'b1;
                    state_d     = IDLE;
                    wcnt_d      = '0;
                end else begin
                    pstop  = 1'b1;
                    wcnt_d = wcnt_q + WCNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    // Output priority: freeze beats hazard beats normal flow.
    always_comb begin
        pc_write   = !(pstop || hazard);
        hazard_out = hazard && !pstop;
        flush      = (bus.branch_taken || bus.jump) && !hazard && !pstop;
    end

    // Sticky timeout flag (set beats clear) and saturating stall counter (clear beats increment).
    always_comb begin
        timeout_d = timeout_q;
        if (bus.stat_clr_i) begin
            timeout_d = 1'b0;
        end
        if (timeout_evt) begin
            timeout_d = 1'b1;
        end
        cnt_d = cnt_q;
        if (bus.stat_clr_i) begin
            cnt_d = '0;
        end else if (!pc_write && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pc_write          = pc_write;
    assign bus.if_id_write_en    = pc_write;
    assign bus.hazard_detected_o = hazard_out;
    assign bus.if_id_flush_o     = flush;
    assign bus.pstop_o           = pstop;
    assign bus.mem_timeout_o     = timeout_q;
    assign bus.stall_count_o     = cnt_q;
endmodule
